// File: rtl/run_detect_pkg.sv
// run_detect_pkg: shared state encoding and running-total limits for the
// run_detect_ctrl sequencer and its bit-serial run detector.
package run_detect_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam int              TOTAL_W   = 16;
    localparam logic [TOTAL_W-1:0] TOTAL_MAX = 16'hFFFF;

    // Saturating increment for the running hit total.
    function automatic logic [TOTAL_W-1:0] sat_inc_total(input logic [TOTAL_W-1:0] value);
        if (value == TOTAL_MAX) begin
            return TOTAL_MAX;
        end
        return value + TOTAL_W'(1);
    endfunction

endpackage

// File: rtl/run_detect_ctrl_detector.sv
// run_detector: bit-serial detector for runs of RUN_LEN equal bits.
// Keeps the last consumed bit and a run count that saturates at RUN_LEN.
// 'hit' is the look-ahead of z: it is high in the cycle a consumed bit
// will leave z=1, so the sequencer can count hits on the same edge.
module run_detector #(
    parameter  int RUN_LEN = 4,
    localparam int CNT_W   = $clog2(RUN_LEN + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             bit_valid,
    input  logic             bit_in,
    output logic             z,
    output logic [CNT_W-1:0] run_cnt,
    output logic             hit
);

    localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(RUN_LEN);

    logic             last_bit;
    logic [CNT_W-1:0] next_cnt;

    // Run count after the bit currently presented (unchanged when idle).
    always_comb begin
        next_cnt = run_cnt;
        if (bit_valid) begin
            if (bit_in == last_bit) begin
                next_cnt = (run_cnt >= RUN_MAX) ? RUN_MAX : run_cnt + CNT_W'(1);
            end else begin
                next_cnt = CNT_W'(1);
            end
        end
    end

    assign hit = bit_valid && (next_cnt >= RUN_MAX);
    assign z   = (run_cnt >= RUN_MAX);

    // Detector history; clear drops the run but keeps the last bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_cnt  <= '0;
            last_bit <= 1'b0;
        end else if (clear) begin
            run_cnt  <= '0;
        end else if (bit_valid) begin
            run_cnt  <= next_cnt;
            last_bit <= bit_in;
        end
    end

endmodule

// File: rtl/run_detect_ctrl.sv
// run_detect_ctrl: accepts words over valid/ready, shifts them MSB-first
// into a run detector and reports per-word hit counts plus a saturating
// running total.
// Optional feature: define RUN_DETECT_CTRL_CLEAR_EN to clear the detector
// run on every accept so each word is scanned independently; otherwise
// detector history carries across words and only reset clears it.
module run_detect_ctrl
    import run_detect_pkg::*;
#(
    parameter  int RUN_LEN = 4,
    parameter  int DATA_W  = 8,
    localparam int HIT_W   = $clog2(DATA_W + 1),
    localparam int BCNT_W  = $clog2(DATA_W)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [HIT_W-1:0]   out_hits,
    output logic               out_last_z,
    output logic               busy,
    output logic [TOTAL_W-1:0] total_hits
);

    localparam int               DET_W    = $clog2(RUN_LEN + 1);
    localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(DATA_W - 1);

    state_t              state;
    state_t              next_state;
    logic [DATA_W-1:0]   shift_reg;
    logic [BCNT_W-1:0]   bit_cnt;
    logic                accept;
    logic                shifting;
    logic                det_clear;
    logic                det_z;
    logic [DET_W-1:0]    det_run_cnt;
    logic                det_hit;
    logic                det_unused;

    assign accept   = (state == IDLE) && in_valid;
    assign shifting = (state == SHIFT);

`ifdef RUN_DETECT_CTRL_CLEAR_EN
    assign det_clear = accept;
`else
    assign det_clear = 1'b0;
`endif

    // The live z and run count are observation points only; the sequencer
    // works from the look-ahead hit.
    assign det_unused = ^{det_z, det_run_cnt};

    run_detector #(
        .RUN_LEN (RUN_LEN)
    ) u_detector (
        .clk       (clk),
        .reset     (reset),
        .clear     (det_clear),
        .bit_valid (shifting),
        .bit_in    (shift_reg[DATA_W-1]),
        .z         (det_z),
        .run_cnt   (det_run_cnt),
        .hit       (det_hit)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake outputs, all decoded from the state register.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_cnt == LAST_BIT) begin
                    next_state = REPORT;
                end
            end
            REPORT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Word load, serial shift and hit bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_reg  <= '0;
            bit_cnt    <= '0;
            out_hits   <= '0;
            out_last_z <= 1'b0;
            total_hits <= '0;
        end else if (accept) begin
            shift_reg <= in_data;
            bit_cnt   <= '0;
            out_hits  <= '0;
        end else if (shifting) begin
            shift_reg  <= {shift_reg[DATA_W-2:0], 1'b0};
            bit_cnt    <= bit_cnt + BCNT_W'(1);
            out_last_z <= det_hit;
            if (det_hit) begin
                out_hits   <= out_hits + HIT_W'(1);
                total_hits <= sat_inc_total(total_hits);
            end
        end
    end

endmodule

// File: tb/tb_run_detect_ctrl.sv
// tb_run_detect_ctrl: directed self-checking bench for run_detect_ctrl.
// Expected values are hand-derived from the detector rules; words whose
// result depends on RUN_DETECT_CTRL_CLEAR_EN carry both expectations.
module tb_run_detect_ctrl;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_hits;
    logic        out_last_z;
    logic        busy;
    logic [15:0] total_hits;

    logic        s_in_valid;
    logic        s_in_ready;
    logic [15:0] s_in_data;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [4:0]  s_out_hits;
    logic        s_out_last_z;
    logic        s_busy;
    logic [15:0] s_total_hits;

    int checks   = 0;
    int failures = 0;

    run_detect_ctrl #(.RUN_LEN(4), .DATA_W(8)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_hits   (out_hits),
        .out_last_z (out_last_z),
        .busy       (busy),
        .total_hits (total_hits)
    );

    // Wide, short-run instance used to reach total_hits saturation quickly.
    run_detect_ctrl #(.RUN_LEN(2), .DATA_W(16)) u_sat (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (s_in_valid),
        .in_ready   (s_in_ready),
        .in_data    (s_in_data),
        .out_valid  (s_out_valid),
        .out_ready  (s_out_ready),
        .out_hits   (s_out_hits),
        .out_last_z (s_out_last_z),
        .busy       (s_busy),
        .total_hits (s_total_hits)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case a wait is ever unbounded by mistake.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one word for a single accept edge; returns #1 after it.
    task automatic applyStimulus(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Count edges from the accept edge until out_valid; -1 on timeout.
    task automatic waitResult(output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic releaseResult();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    // Directed sequence.
    initial begin
        int lat;
        int exp_total;
        int exp_hits;
        int seen_valid;
        int words;
        int target;
        int model_total;
        int cycles;
        int pre_sat_word;
        int pre_sat_total;
        logic [31:0] obs_pre;

        reset       = 1'b1;
        in_valid    = 1'b0;
        in_data     = 8'h00;
        out_ready   = 1'b0;
        s_in_valid  = 1'b0;
        s_in_data   = 16'hFFFF;
        s_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_hits", 32'(out_hits), 32'd0);
        checkOutput("rst_last_z", 32'(out_last_z), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_total", 32'(total_hits), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // 0x00 from reset: hits on bits 4..8.
        applyStimulus(8'h00);
        waitResult(lat);
        checkOutput("w00_latency", 32'(lat), 32'd8);
        checkOutput("w00_hits", 32'(out_hits), 32'd5);
        checkOutput("w00_last_z", 32'(out_last_z), 32'd1);
        checkOutput("w00_total", 32'(total_hits), 32'd5);
        checkOutput("w00_busy", 32'(busy), 32'd1);
        checkOutput("w00_in_ready", 32'(in_ready), 32'd0);
        releaseResult();
        checkOutput("w00_idle", 32'(in_ready), 32'd1);
        exp_total = 5;

        // 0xAA alternates: no hits in either mode.
        applyStimulus(8'hAA);
        waitResult(lat);
        checkOutput("wAA_hits", 32'(out_hits), 32'd0);
        checkOutput("wAA_last_z", 32'(out_last_z), 32'd0);
        checkOutput("wAA_total", 32'(total_hits), 32'(exp_total));
        releaseResult();

        // 0xF0 after a trailing 0 of 0xAA: one hit per nibble.
        applyStimulus(8'hF0);
        waitResult(lat);
        exp_total += 2;
        checkOutput("wF0_hits", 32'(out_hits), 32'd2);
        checkOutput("wF0_last_z", 32'(out_last_z), 32'd1);
        checkOutput("wF0_total", 32'(total_hits), 32'(exp_total));
        releaseResult();

        // 0x0F after a saturated 0-run, then held in REPORT.
`ifdef RUN_DETECT_CTRL_CLEAR_EN
        exp_hits = 2;
`else
        exp_hits = 5;
`endif
        applyStimulus(8'h0F);
        waitResult(lat);
        exp_total += exp_hits;
        checkOutput("w0F_latency", 32'(lat), 32'd8);
        checkOutput("w0F_total", 32'(total_hits), 32'(exp_total));
        in_valid = 1'b1;
        in_data  = 8'hFF;
        for (int k = 0; k < 10; k++) begin
            checkOutput("hold_hits", 32'(out_hits), 32'(exp_hits));
            checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
            checkOutput("hold_out_valid", 32'(out_valid), 32'd1);
            @(posedge clk);
            #1;
        end
        checkOutput("hold_last_z", 32'(out_last_z), 32'd1);
        releaseResult();
        checkOutput("rel_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rel_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("next_accept_busy", 32'(busy), 32'd1);

        // 0xFF following 0x0F's trailing 1-run.
`ifdef RUN_DETECT_CTRL_CLEAR_EN
        exp_hits = 5;
`else
        exp_hits = 8;
`endif
        waitResult(lat);
        exp_total += exp_hits;
        checkOutput("wFF_latency", 32'(lat), 32'd8);
        checkOutput("wFF_hits", 32'(out_hits), 32'(exp_hits));
        checkOutput("wFF_total", 32'(total_hits), 32'(exp_total));
        releaseResult();

        // Reset during the third SHIFT cycle aborts the word.
        applyStimulus(8'hFF);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
        checkOutput("abort_hits", 32'(out_hits), 32'd0);
        checkOutput("abort_last_z", 32'(out_last_z), 32'd0);
        checkOutput("abort_total", 32'(total_hits), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        seen_valid = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen_valid++;
        end
        checkOutput("abort_no_result", 32'(seen_valid), 32'd0);

        // Fresh history: 0x0F gives two hits, then 0xF0 depends on mode.
        applyStimulus(8'h0F);
        waitResult(lat);
        checkOutput("post_0F_hits", 32'(out_hits), 32'd2);
        checkOutput("post_0F_total", 32'(total_hits), 32'd2);
        releaseResult();
`ifdef RUN_DETECT_CTRL_CLEAR_EN
        exp_hits = 2;
`else
        exp_hits = 5;
`endif
        applyStimulus(8'hF0);
        waitResult(lat);
        checkOutput("post_F0_hits", 32'(out_hits), 32'(exp_hits));
        checkOutput("post_F0_last_z", 32'(out_last_z), 32'd1);
        checkOutput("post_F0_total", 32'(total_hits), 32'(2 + exp_hits));
        releaseResult();

        // Saturation: stream 0xFFFF words into the RUN_LEN=2, DATA_W=16 unit.
        // First word from reset yields 15 hits; later words 16 (or 15 when
        // the run is cleared per word).
`ifdef RUN_DETECT_CTRL_CLEAR_EN
        target = 4371;
`else
        target = 4098;
`endif
        pre_sat_word  = target - 3;
        pre_sat_total = 0;
        model_total   = 0;
        words         = 0;
        cycles        = 0;
        obs_pre       = 32'hDEAD_BEEF;
        s_in_valid    = 1'b1;
        s_out_ready   = 1'b1;
        while (words < target && cycles < 90000) begin
            @(posedge clk);
            #1;
            cycles++;
            if (s_out_valid) begin
                words++;
`ifdef RUN_DETECT_CTRL_CLEAR_EN
                model_total += 15;
`else
                model_total += (words == 1) ? 15 : 16;
`endif
                if (words == pre_sat_word) begin
                    obs_pre       = 32'(s_total_hits);
                    pre_sat_total = model_total;
                end
            end
        end
        s_in_valid  = 1'b0;
        s_out_ready = 1'b0;
        checkOutput("sat_words", 32'(words), 32'(target));
        checkOutput("sat_pre_total", obs_pre, 32'(pre_sat_total));
        checkOutput("sat_final_total", 32'(s_total_hits), 32'hFFFF);
`ifdef RUN_DETECT_CTRL_CLEAR_EN
        checkOutput("sat_word_hits", 32'(s_out_hits), 32'd15);
`else
        checkOutput("sat_word_hits", 32'(s_out_hits), 32'd16);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
